// File: rtl/hdmi_cfg_sequencer_if.sv
// Writer-side bus between the HDMI config sequencer (master) and the i2c_writer byte engine (slave).
// Handshake: master holds I2C_GO high for two cycles then low; the writer drops I2C_END_OK after GO falls,
// raises it when the transfer completes, and presents I2C_ACK_OK (1 = NACK seen) no later than that rise.
interface hdmi_cfg_sequencer_if;
  logic        I2C_GO;
  logic [15:0] I2C_REG_DATA;
  logic [7:0]  I2C_SLAVE_ADDRESS;
  logic [7:0]  I2C_BYTE_NUM;
  logic        I2C_END_OK;
  logic        I2C_ACK_OK;

  modport master (
    output I2C_GO,
    output I2C_REG_DATA,
    output I2C_SLAVE_ADDRESS,
    output I2C_BYTE_NUM,
    input  I2C_END_OK,
    input  I2C_ACK_OK
  );

  modport slave (
    input  I2C_GO,
    input  I2C_REG_DATA,
    input  I2C_SLAVE_ADDRESS,
    input  I2C_BYTE_NUM,
    output I2C_END_OK,
    output I2C_ACK_OK
  );
endinterface

// File: rtl/hdmi_cfg_sequencer.sv
// Walks a {reg_addr, reg_value} ROM table and issues one 2-byte I2C write per entry,
// with retry on NACK/timeout, delay entries, end marker, and done/fail status.
module hdmi_cfg_sequencer #(
  parameter int          NUM_REGS   = 64,
  parameter logic [7:0]  SLAVE_ADDR = 8'h72,
  parameter logic [19:0] INIT_DELAY = 20'd50000,
  parameter logic [15:0] TIMEOUT    = 16'd4000,
  parameter int          MAX_RETRY  = 3
) (
  input  logic                        PT_CK,
  input  logic                        RESET_N,
  input  logic                        START,
  hdmi_cfg_sequencer_if.master        i2c,
  output logic [7:0]                  TBL_ADDR,
  input  logic [15:0]                 TBL_DATA,
  output logic                        BUSY,
  output logic                        DONE,
  output logic                        ERROR,
  output logic [7:0]                  ERR_INDEX,
  output logic [3:0]                  dbg_state
);

  localparam int             RW        = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0]  RETRY_LIM = RW'(MAX_RETRY);
  localparam logic [8:0]     IDX_END   = 9'(NUM_REGS);

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH,
    S_LATCH,
    S_GO_HI,
    S_GO_LO,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_CHECK,
    S_FAULT,
    S_DELAY,
    S_FINISH,
    S_FAIL
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    index, index_nxt;
  logic [15:0]   reg_data, reg_data_nxt;
  logic [RW-1:0] retry_cnt, retry_nxt;
  logic [19:0]   init_cnt, init_nxt;
  logic [15:0]   to_cnt, to_nxt;
  logic [17:0]   dly_cnt, dly_nxt;
  logic          go_cnt, go_nxt;
  logic [7:0]    err_index, err_index_nxt;

  logic [RW-1:0] retry_inc;
  logic          idx_at_end;

  assign retry_inc  = retry_cnt + RW'(1);
  assign idx_at_end = (({1'b0, index}) + 9'd1) == IDX_END;

  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_INIT;
      index     <= '0;
      reg_data  <= '0;
      retry_cnt <= '0;
      init_cnt  <= '0;
      to_cnt    <= '0;
      dly_cnt   <= '0;
      go_cnt    <= 1'b0;
      err_index <= '0;
    end else begin
      state     <= state_nxt;
      index     <= index_nxt;
      reg_data  <= reg_data_nxt;
      retry_cnt <= retry_nxt;
      init_cnt  <= init_nxt;
      to_cnt    <= to_nxt;
      dly_cnt   <= dly_nxt;
      go_cnt    <= go_nxt;
      err_index <= err_index_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    index_nxt     = index;
    reg_data_nxt  = reg_data;
    retry_nxt     = retry_cnt;
    init_nxt      = init_cnt;
    to_nxt        = to_cnt;
    dly_nxt       = dly_cnt;
    go_nxt        = go_cnt;
    err_index_nxt = err_index;

    unique case (state)
      S_INIT: begin
        if (START || (init_cnt + 20'd1 >= INIT_DELAY)) begin
          state_nxt = S_FETCH;
        end else begin
          init_nxt = init_cnt + 20'd1;
        end
      end

      S_FETCH: state_nxt = S_LATCH;

      S_LATCH: begin
        if (TBL_DATA == 16'hFFFF) begin
          state_nxt = S_FINISH;
        end else if (TBL_DATA[15:8] == 8'hFE) begin
          dly_nxt   = {TBL_DATA[7:0], 10'b0};
          state_nxt = S_DELAY;
        end else begin
          reg_data_nxt = TBL_DATA;
          retry_nxt    = '0;
          go_nxt       = 1'b0;
          state_nxt    = S_GO_HI;
        end
      end

      // go_cnt marks the second GO cycle so the pulse is exactly two cycles wide.
      S_GO_HI: begin
        if (go_cnt) begin
          go_nxt    = 1'b0;
          state_nxt = S_GO_LO;
        end else begin
          go_nxt = 1'b1;
        end
      end

      S_GO_LO: begin
        to_nxt    = '0;
        state_nxt = S_WAIT_BUSY;
      end

      S_WAIT_BUSY: begin
        if (!i2c.I2C_END_OK) begin
          to_nxt    = '0;
          state_nxt = S_WAIT_DONE;
        end else if (to_cnt >= TIMEOUT) begin
          state_nxt = S_FAULT;
        end else begin
          to_nxt = to_cnt + 16'd1;
        end
      end

      S_WAIT_DONE: begin
        if (i2c.I2C_END_OK) begin
          state_nxt = S_CHECK;
        end else if (to_cnt >= TIMEOUT) begin
          state_nxt = S_FAULT;
        end else begin
          to_nxt = to_cnt + 16'd1;
        end
      end

      S_CHECK: begin
        if (i2c.I2C_ACK_OK) begin
          state_nxt = S_FAULT;
        end else begin
          index_nxt = index + 8'd1;
          state_nxt = idx_at_end ? S_FINISH : S_FETCH;
        end
      end

      S_FAULT: begin
        retry_nxt = retry_inc;
        if (retry_inc < RETRY_LIM) begin
          go_nxt    = 1'b0;
          state_nxt = S_GO_HI;
        end else begin
          err_index_nxt = index;
          state_nxt     = S_FAIL;
        end
      end

      // A loaded count of N occupies N+1 cycles; the table never wraps past the last entry.
      S_DELAY: begin
        if (dly_cnt == 18'd0) begin
          index_nxt = index + 8'd1;
          state_nxt = idx_at_end ? S_FINISH : S_FETCH;
        end else begin
          dly_nxt = dly_cnt - 18'd1;
        end
      end

      S_FINISH, S_FAIL: begin
        if (START) begin
          index_nxt = '0;
          state_nxt = S_FETCH;
        end
      end

      default: state_nxt = S_INIT;
    endcase
  end

  assign i2c.I2C_GO            = (state == S_GO_HI);
  assign i2c.I2C_REG_DATA      = reg_data;
  assign i2c.I2C_SLAVE_ADDRESS = SLAVE_ADDR;
  assign i2c.I2C_BYTE_NUM      = 8'd2;

  assign TBL_ADDR  = index;
  assign BUSY      = (state != S_INIT) && (state != S_FINISH) && (state != S_FAIL);
  assign DONE      = (state == S_FINISH);
  assign ERROR     = (state == S_FAIL);
  assign ERR_INDEX = err_index;
  assign dbg_state = state;

endmodule

// File: doc/hdmi_cfg_sequencer.md
# hdmi_cfg_sequencer

Register-table sequencer that configures the HDMI transmitter over I2C by driving the `i2c_writer` byte engine. After reset and a power-up settle delay, it walks a 16-bit register table (`{reg_addr, reg_value}` per entry), issuing one 2-byte I2C write per entry. It handles the `GO`/`END_OK` handshake, retries NACKed or hung transfers, supports delay and end-of-table entries, and reports done or fail to the overlay control logic.

## Interface
Parameters:
- `NUM_REGS`, 64: maximum table entries; table index wraps are illegal, so the sequence ends at `NUM_REGS` entries.
- `SLAVE_ADDR`, 8'h72: 8-bit write address driven to the writer.
- `INIT_DELAY`, 20'd50000: `PT_CK` cycles to wait after reset before auto-start.
- `TIMEOUT`, 16'd4000: maximum cycles allowed in each writer-wait state.
- `MAX_RETRY`, 3: attempts per entry before failing.

Ports:
- `PT_CK` in 1: I2C phase clock, shared with the writer.
- `RESET_N` in 1: asynchronous, active-low reset.
- `START` in 1: level-sampled restart request.
- `I2C_END_OK` in 1: writer idle/complete flag.
- `I2C_ACK_OK` in 1: writer NACK flag; 1 means at least one acknowledge bit was sampled high.
- `I2C_GO` out 1: writer start request.
- `I2C_REG_DATA` out 16: `{reg_addr, reg_value}` sent to the writer.
- `I2C_SLAVE_ADDRESS` out 8: constant `SLAVE_ADDR`.
- `I2C_BYTE_NUM` out 8: constant 2.
- `TBL_ADDR` out 8: table index.
- `TBL_DATA` in 16: synchronous-ROM word for `TBL_ADDR`, valid one cycle after the address.
- `BUSY` out 1: sequence in progress.
- `DONE` out 1: table completed.
- `ERROR` out 1: entry failed after `MAX_RETRY` attempts.
- `ERR_INDEX` out 8: index of the failing entry.

## Operation
- **Reset values:** `I2C_GO`=0, `I2C_REG_DATA`=0, `TBL_ADDR`=0, `BUSY`=0, `DONE`=0, `ERROR`=0, `ERR_INDEX`=0, retry count 0, state `INIT`. `I2C_SLAVE_ADDRESS` and `I2C_BYTE_NUM` are constant.
- **INIT:** count `INIT_DELAY` cycles, then go to `FETCH` with `BUSY`=1.
- **FETCH:** drive `TBL_ADDR` with the current index, then go to `LATCH`.
- **LATCH:** register `TBL_DATA`, then decode:
  - `16'hFFFF` → `FINISH`.
  - `[15:8]==8'hFE` → `DELAY`, loading `TBL_DATA[7:0]*1024` cycles.
  - Otherwise, load `I2C_REG_DATA`, clear the retry count, and go to `GO_HI`.
- **GO_HI:** hold `I2C_GO`=1 for exactly 2 cycles, then `GO_LO`.
- **GO_LO:** `I2C_GO`=0, then `WAIT_BUSY`.
- **WAIT_BUSY:** wait for `I2C_END_OK`=0, then `WAIT_DONE`. Exceeding `TIMEOUT` goes to `FAULT`.
- **WAIT_DONE:** wait for `I2C_END_OK`=1, then `CHECK`. Exceeding `TIMEOUT` goes to `FAULT`.
- **CHECK:** if `I2C_ACK_OK`=1 → `FAULT`. Otherwise, increment the index. If the index equals `NUM_REGS` → `FINISH`, else → `FETCH`.
- **FAULT:** increment the retry count.
  - If retries are below `MAX_RETRY`, go to `GO_HI` with the same `I2C_REG_DATA`.
  - Otherwise, go to `FAIL`, set `ERROR`=1 and `ERR_INDEX`=index, and clear `BUSY`.
- **DELAY:** count down to 0, increment the index, then `FETCH`. A count of 0 takes 1 cycle.
- **FINISH:** `DONE`=1, `BUSY`=0; hold.
- **START:**
  - In `FINISH` or `FAIL`: clear `DONE`/`ERROR`, set the index to 0, and go to `FETCH` without `INIT_DELAY`.
  - While `BUSY`=1: ignored.
  - In `INIT`: skips the remaining delay.

## Timing
- All state is registered on posedge `PT_CK`. `RESET_N` low immediately forces reset values, including mid-transfer. `I2C_GO` drops asynchronously, and the writer is reset by the same net.
- Table read latency is 1 cycle, so `FETCH`→`LATCH` costs 2 cycles per entry before `GO`.
- `I2C_REG_DATA` is stable from `LATCH` until the next `LATCH`, covering the whole transfer including retries.
- `GO` handshake: `I2C_GO` is high for 2 cycles, then low. The writer is required to drop `END_OK` after `GO` falls and raise it on completion.
- `I2C_ACK_OK` is sampled only in `CHECK`, the cycle after `END_OK` rises.
- The timeout counter clears on entry to each wait state and uses a `>=TIMEOUT` compare.
- Retry count width is `$clog2(MAX_RETRY+1)`. The delay counter is 18 bits.

## Test plan
- **Normal table:** 3 entries (`1234`, `5678`, `9ABC`) then `FFFF`, with a model writer that always ACKs. Required: 3 `GO` pulses, each 2 cycles; `I2C_REG_DATA` equals each entry in order; `DONE`=1 and `BUSY`=0 after the third `END_OK` rise; `TBL_ADDR` ends at 3.
- **Delay entry:** `FE02` between two writes. Required: the gap from the `END_OK` rise to the next `GO` is 2048 cycles plus fixed overhead (`CHECK`, `FETCH`, `LATCH`, `DELAY` exit).
- **Single NACK:** `ACK_OK`=1 on the first attempt of entry 1 only. Required: a second `GO` with identical `REG_DATA`, then the sequence completes with `ERROR`=0.
- **Persistent NACK:** `MAX_RETRY`=3 and entry 2 always NACKs. Required: exactly 3 `GO` pulses for entry 2; `ERROR`=1, `ERR_INDEX`=2, `BUSY`=0, `DONE`=0.
- **Hung writer:** `END_OK` stuck at 1. Required: timeout after `TIMEOUT` cycles in `WAIT_BUSY`, retries, then `FAIL`. A `START` pulse afterwards restarts at index 0 with `ERROR` cleared.
- **Reset mid-transfer:** assert `RESET_N` low during `WAIT_DONE`. Required: all outputs reach reset values immediately, and after release `INIT_DELAY` elapses before the first `GO`.
